// File: rtl/window_match.sv
// Classifies a value stream against a bank of programmable half-open windows [lower, upper),
// with a one-cycle registered result plus per-window sticky flags and saturating hit counters.
module window_match #(
    parameter int P_width       = 16,
    parameter int P_channels    = 4,
    parameter int P_count_width = 8,
    localparam int IW           = $clog2(P_channels)
) (
    input  logic                     I_clock,
    input  logic                     I_reset,
    input  logic [P_width-1:0]       I_value,
    input  logic                     I_valid,
    input  logic                     I_cfg_write,
    input  logic [IW-1:0]            I_cfg_index,
    input  logic [P_width-1:0]       I_cfg_lower,
    input  logic [P_width-1:0]       I_cfg_upper,
    input  logic                     I_cfg_enable,
    input  logic                     I_clear,
    input  logic [IW-1:0]            I_cnt_index,
    output logic                     O_valid,
    output logic [P_channels-1:0]    O_hit,
    output logic                     O_any,
    output logic                     O_miss,
    output logic [IW-1:0]            O_index,
    output logic [P_channels-1:0]    O_sticky,
    output logic [P_count_width-1:0] O_count
);

    logic [P_width-1:0]       lower_q  [P_channels];
    logic [P_width-1:0]       upper_q  [P_channels];
    logic [P_channels-1:0]    enable_q;
    logic [P_count_width-1:0] count_q  [P_channels];
    logic [P_channels-1:0]    sticky_q;

    logic                     valid_q;
    logic [P_channels-1:0]    hit_q;
    logic                     any_q;
    logic                     miss_q;
    logic [IW-1:0]            index_q;

    logic [P_channels-1:0]    hit_d;
    logic [IW-1:0]            index_d;
    logic                     cfg_ok;
    logic                     cnt_ok;

    assign cfg_ok = (32'(I_cfg_index) < P_channels);
    assign cnt_ok = (32'(I_cnt_index) < P_channels);

    // Matching uses the config registers as they stand before this edge, so a
    // simultaneous config write only affects values from the next cycle on.
    always_comb begin
        hit_d = '0;
        for (int n = 0; n < P_channels; n++) begin
            hit_d[n] = I_valid && enable_q[n]
                       && (lower_q[n] < upper_q[n])
                       && (I_value >= lower_q[n])
                       && (I_value < upper_q[n]);
        end
    end

    always_comb begin
        index_d = '0;
        for (int n = P_channels - 1; n >= 0; n--) begin
            if (hit_d[n]) index_d = IW'(n);
        end
    end

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            valid_q <= 1'b0;
            hit_q   <= '0;
            any_q   <= 1'b0;
            miss_q  <= 1'b0;
            index_q <= '0;
        end else begin
            valid_q <= I_valid;
            hit_q   <= hit_d;
            any_q   <= |hit_d;
            miss_q  <= I_valid && !(|hit_d);
            index_q <= index_d;
        end
    end

    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            for (int n = 0; n < P_channels; n++) begin
                lower_q[n] <= '0;
                upper_q[n] <= '0;
            end
            enable_q <= '0;
        end else if (I_cfg_write && cfg_ok) begin
            lower_q[I_cfg_index]  <= I_cfg_lower;
            upper_q[I_cfg_index]  <= I_cfg_upper;
            enable_q[I_cfg_index] <= I_cfg_enable;
        end
    end

    // Clear takes priority over a hit landing on the same edge.
    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            for (int n = 0; n < P_channels; n++) count_q[n] <= '0;
            sticky_q <= '0;
        end else if (I_clear) begin
            for (int n = 0; n < P_channels; n++) count_q[n] <= '0;
            sticky_q <= '0;
        end else begin
            for (int n = 0; n < P_channels; n++) begin
                if (hit_d[n] && (count_q[n] != '1)) begin
                    count_q[n] <= count_q[n] + P_count_width'(1);
                end
            end
            sticky_q <= sticky_q | hit_d;
        end
    end

    always_comb begin
        O_count = '0;
        if (cnt_ok) O_count = count_q[I_cnt_index];
    end

    assign O_valid  = valid_q;
    assign O_hit    = hit_q;
    assign O_any    = any_q;
    assign O_miss   = miss_q;
    assign O_index  = index_q;
    assign O_sticky = sticky_q;

endmodule

// File: tb/tb_window_match.sv
// Randomised and directed checks of window_match against a plain arithmetic window model.
module tb_window_match;

    logic        I_clock = 1'b0;
    logic        I_reset;
    logic [15:0] I_value;
    logic        I_valid;
    logic        I_cfg_write;
    logic [1:0]  I_cfg_index;
    logic [15:0] I_cfg_lower;
    logic [15:0] I_cfg_upper;
    logic        I_cfg_enable;
    logic        I_clear;
    logic [1:0]  I_cnt_index;
    logic        O_valid;
    logic [3:0]  O_hit;
    logic        O_any;
    logic        O_miss;
    logic [1:0]  O_index;
    logic [3:0]  O_sticky;
    logic [7:0]  O_count;

    int tests = 0;
    int fails = 0;

    // Reference model: window bounds as integers, counters as integers.
    int       m_lo[4];
    int       m_hi[4];
    bit       m_en[4];
    int       m_cnt[4];
    bit [3:0] m_sticky;
    bit       e_valid;
    bit [3:0] e_hit;
    bit [1:0] e_index;

    window_match dut (
        .I_clock(I_clock), .I_reset(I_reset), .I_value(I_value), .I_valid(I_valid),
        .I_cfg_write(I_cfg_write), .I_cfg_index(I_cfg_index), .I_cfg_lower(I_cfg_lower),
        .I_cfg_upper(I_cfg_upper), .I_cfg_enable(I_cfg_enable), .I_clear(I_clear),
        .I_cnt_index(I_cnt_index), .O_valid(O_valid), .O_hit(O_hit), .O_any(O_any),
        .O_miss(O_miss), .O_index(O_index), .O_sticky(O_sticky), .O_count(O_count)
    );

    always #5 I_clock = ~I_clock;

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            m_lo[n] = 0; m_hi[n] = 0; m_en[n] = 0; m_cnt[n] = 0;
        end
        m_sticky = '0; e_valid = 0; e_hit = '0; e_index = '0;
    endtask

    function automatic logic [8:0] exp_out();
        return {e_valid, e_hit, |e_hit, e_valid & ~(|e_hit), e_index};
    endfunction

    // Drives one cycle of stimulus, advances the model, and returns at posedge+1.
    task automatic cycle(input int v, input bit vld, input bit wr, input int widx,
                         input int lo, input int hi, input bit en, input bit clr);
        I_value = 16'(v); I_valid = vld; I_cfg_write = wr; I_cfg_index = 2'(widx);
        I_cfg_lower = 16'(lo); I_cfg_upper = 16'(hi); I_cfg_enable = en; I_clear = clr;
        e_valid = vld;
        for (int n = 0; n < 4; n++) e_hit[n] = vld && m_en[n] && v >= m_lo[n] && v < m_hi[n];
        e_index = '0;
        for (int n = 3; n >= 0; n--) if (e_hit[n]) e_index = 2'(n);
        for (int n = 0; n < 4; n++) begin
            if (clr) m_cnt[n] = 0;
            else if (e_hit[n] && m_cnt[n] < 255) m_cnt[n] = m_cnt[n] + 1;
        end
        m_sticky = clr ? 4'b0 : (m_sticky | e_hit);
        if (wr) begin
            m_lo[widx] = lo; m_hi[widx] = hi; m_en[widx] = en;
        end
        @(posedge I_clock);
        #1;
        I_valid = 0; I_cfg_write = 0; I_clear = 0;
    endtask

    task automatic test_reset();
        I_reset = 1; I_value = 0; I_valid = 0; I_cfg_write = 0; I_cfg_index = 0;
        I_cfg_lower = 0; I_cfg_upper = 0; I_cfg_enable = 0; I_clear = 0; I_cnt_index = 0;
        model_reset();
        repeat (2) @(posedge I_clock);
        #1;
        tests++;
        if ({O_valid, O_hit, O_any, O_miss, O_index, O_sticky, O_count} !== 21'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0",
                     {O_valid, O_hit, O_any, O_miss, O_index, O_sticky, O_count});
        end
        I_reset = 0;
        for (int i = 0; i < 4; i++) begin
            cycle($urandom_range(0, 16'hFFFF), 1, 0, 0, 0, 0, 0, 0);
            tests++;
            if ({O_valid, O_miss, O_any} !== 3'b110) begin
                fails++;
                $display("FAIL reset_windows_miss step%0d: got valid/miss/any %b required 110",
                         i, {O_valid, O_miss, O_any});
            end
        end
    endtask

    task automatic test_basic();
        int vals[4] = '{16'h1FFF, 16'h2000, 16'h3FFF, 16'h4000};
        bit hit0[4] = '{0, 1, 1, 0};
        cycle(0, 0, 1, 0, 16'h2000, 16'h4000, 1, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(vals[i], 1, 0, 0, 0, 0, 0, 0);
            tests++;
            if (O_hit[0] !== hit0[i] || O_miss !== !hit0[i]) begin
                fails++;
                $display("FAIL basic_window0 step%0d: got hit0=%b miss=%b required hit0=%b miss=%b",
                         i, O_hit[0], O_miss, hit0[i], !hit0[i]);
            end
            tests++;
            if ({O_valid, O_hit, O_any, O_miss, O_index} !== exp_out()) begin
                fails++;
                $display("FAIL basic_outputs step%0d: got %b required %b",
                         i, {O_valid, O_hit, O_any, O_miss, O_index}, exp_out());
            end
        end
    endtask

    task automatic test_overlap();
        cycle(0, 0, 1, 1, 16'h1000, 16'h3000, 1, 0);
        cycle(0, 0, 1, 2, 16'h2800, 16'h2900, 1, 0);
        cycle(16'h2850, 1, 0, 0, 0, 0, 0, 0);
        tests++;
        if (O_hit !== 4'b0111 || O_index !== 2'd0 || O_any !== 1'b1 || O_miss !== 1'b0) begin
            fails++;
            $display("FAIL overlap_outputs: got hit=%b idx=%0d any=%b miss=%b required 0111/0/1/0",
                     O_hit, O_index, O_any, O_miss);
        end
        for (int n = 0; n < 4; n++) begin
            I_cnt_index = 2'(n);
            #1;
            tests++;
            if (O_count !== 8'(m_cnt[n])) begin
                fails++;
                $display("FAIL overlap_count%0d: got %0d required %0d", n, O_count, m_cnt[n]);
            end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) cycle(16'h2100, 1, 0, 0, 0, 0, 0, 0);
        I_cnt_index = 0;
        #1;
        tests++;
        if (O_count !== 8'd255 || O_sticky[0] !== 1'b1) begin
            fails++;
            $display("FAIL saturate_count0: got count=%0d sticky0=%b required 255/1",
                     O_count, O_sticky[0]);
        end
        cycle(16'h2100, 1, 0, 0, 0, 0, 0, 1);
        tests++;
        if (O_count !== 8'd0 || O_sticky !== 4'b0 || O_hit[0] !== 1'b1 || O_valid !== 1'b1) begin
            fails++;
            $display("FAIL clear_wins: got count=%0d sticky=%b hit0=%b valid=%b required 0/0000/1/1",
                     O_count, O_sticky, O_hit[0], O_valid);
        end
    endtask

    task automatic test_empty();
        cycle(0, 0, 1, 3, 16'h5000, 16'h5000, 1, 0);
        cycle(16'h5000, 1, 0, 0, 0, 0, 0, 0);
        tests++;
        if (O_hit[3] !== 1'b0) begin
            fails++;
            $display("FAIL empty_zero_width: got hit3=%b required 0", O_hit[3]);
        end
        cycle(0, 0, 1, 3, 16'h6000, 16'h5000, 1, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(i == 0 ? 16'h5000 : 16'h5800, 1, 0, 0, 0, 0, 0, 0);
            tests++;
            if (O_hit[3] !== 1'b0 || O_miss !== 1'b1) begin
                fails++;
                $display("FAIL empty_inverted step%0d: got hit3=%b miss=%b required 0/1",
                         i, O_hit[3], O_miss);
            end
        end
    endtask

    task automatic test_cfg_same_cycle();
        cycle(16'h2000, 1, 1, 0, 16'h2000, 16'h4000, 0, 0);
        tests++;
        if (O_hit[0] !== 1'b1) begin
            fails++;
            $display("FAIL cfg_old_applies: got hit0=%b required 1", O_hit[0]);
        end
        cycle(16'h2000, 1, 0, 0, 0, 0, 0, 0);
        tests++;
        if (O_hit[0] !== 1'b0 || {O_valid, O_hit, O_any, O_miss, O_index} !== exp_out()) begin
            fails++;
            $display("FAIL cfg_new_applies: got %b required %b (hit0 must be 0)",
                     {O_valid, O_hit, O_any, O_miss, O_index}, exp_out());
        end
    endtask

    task automatic test_random();
        int lo, hi, v;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            lo = $urandom_range(0, 16'hFFFF);
            hi = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16'hFFFF)
                                              : lo + $urandom_range(0, 24000);
            if (hi > 16'hFFFF) hi = 16'hFFFF;
            v = $urandom_range(0, 16'hFFFF);
            cycle(v, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3),
                  lo, hi, $urandom_range(0, 4) != 0, $urandom_range(0, 29) == 0);
            I_cnt_index = 2'($urandom_range(0, 3));
            #1;
            tests++;
            if ({O_valid, O_hit, O_any, O_miss, O_index} !== exp_out()
                || O_sticky !== m_sticky || O_count !== 8'(m_cnt[I_cnt_index])) begin
                fails++;
                bad++;
                if (bad < 10)
                    $display("FAIL random step%0d: got out=%b sticky=%b count=%0d required %b/%b/%0d",
                             i, {O_valid, O_hit, O_any, O_miss, O_index}, O_sticky, O_count,
                             exp_out(), m_sticky, m_cnt[I_cnt_index]);
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 0, 1, 0, 0, 16'hFFFF, 1, 0);
        for (int i = 0; i < 3; i++) cycle(16'h1234, 1, 0, 0, 0, 0, 0, 0);
        I_value = 16'h1234; I_valid = 1;
        #3;
        I_reset = 1;
        #1;
        tests++;
        if ({O_valid, O_hit, O_any, O_miss, O_index, O_sticky} !== 13'd0) begin
            fails++;
            $display("FAIL async_reset_outputs: got %b required 0",
                     {O_valid, O_hit, O_any, O_miss, O_index, O_sticky});
        end
        for (int n = 0; n < 4; n++) begin
            I_cnt_index = 2'(n);
            #1;
            tests++;
            if (O_count !== 8'd0) begin
                fails++;
                $display("FAIL async_reset_count%0d: got %0d required 0", n, O_count);
            end
        end
        @(posedge I_clock);
        #1;
        I_reset = 0;
        I_valid = 0;
        model_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        tests++;
        if (O_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_inflight_discard: got valid=%b required 0", O_valid);
        end
        cycle(16'h1234, 1, 0, 0, 0, 0, 0, 0);
        tests++;
        if ({O_valid, O_hit, O_any, O_miss, O_index} !== 9'b1_0000_0_1_00) begin
            fails++;
            $display("FAIL reset_cfg_cleared: got %b required 100000100",
                     {O_valid, O_hit, O_any, O_miss, O_index});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_saturate();
        test_empty();
        test_cfg_same_cycle();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/window_match.md
WINDOW_MATCH -- requirements
Module: window_match

Interface
REQ-001 SHALL have parameter P_width, default 16, bit width of compared value and window bounds.
REQ-002 SHALL have parameter P_channels, default 4 (legal >= 2), number of independent windows.
REQ-003 SHALL have parameter P_count_width, default 8, width of each per-channel hit counter.
REQ-004 SHALL define local index width IW = $clog2(P_channels).
REQ-005 SHALL have ports, one per line:
 I_clock  input  1  sole clock, rising edge.
 I_reset  input  1  asynchronous, active-high reset.
 I_value  input  P_width  value to classify.
 I_valid  input  1  I_value qualifies this cycle.
 I_cfg_write  input  1  window config write strobe.
 I_cfg_index  input  IW  window being written.
 I_cfg_lower  input  P_width  inclusive lower bound.
 I_cfg_upper  input  P_width  exclusive upper bound.
 I_cfg_enable  input  1  window enable.
 I_clear  input  1  clears sticky flags and counters.
 I_cnt_index  input  IW  counter read select.
 O_valid  output  1  registered result valid.
 O_hit  output  P_channels  per-window match, registered.
 O_any  output  1  OR of O_hit.
 O_miss  output  1  O_valid and no window matched.
 O_index  output  IW  lowest-numbered matching window, 0 if none.
 O_sticky  output  P_channels  per-window hit seen since clear.
 O_count  output  P_count_width  hit counter of window I_cnt_index.

Function
REQ-006 SHALL hold per window: lower, upper, enable registers.
REQ-007 SHALL treat window n as matching when enable[n] and lower[n] <= I_value < upper[n], unsigned compare.
REQ-008 SHALL never match a window with lower >= upper (empty window), regardless of enable.
REQ-009 SHALL register results: O_valid, O_hit, O_any, O_miss, O_index reflect I_value/I_valid of the previous cycle (latency 1).
REQ-010 SHALL drive O_hit, O_any, O_index to 0 on any cycle where O_valid is 0; O_miss = O_valid and not O_any.
REQ-011 SHALL priority-encode O_index to the lowest set bit of O_hit.
REQ-012 SHALL on I_cfg_write update lower/upper/enable of window I_cfg_index at the clock edge; I_cfg_index >= P_channels SHALL be ignored.
REQ-013 SHALL evaluate a value presented in the same cycle as a config write against the old config; new config applies from the next cycle.
REQ-014 SHALL set O_sticky[n] on the edge that registers a hit on window n; bits remain set until I_clear or reset.
REQ-015 SHALL increment counter n by 1 on each edge registering a hit on window n, saturating at all-ones (no wrap).
REQ-016 SHALL on I_clear zero all counters and O_sticky at the edge; a hit in the same cycle as I_clear SHALL be dropped (clear wins); O_hit/O_valid pipeline unaffected.
REQ-017 SHALL drive O_count combinationally from counter I_cnt_index; out-of-range index reads 0.
REQ-018 SHALL count overlapping windows independently: one value may hit, set sticky, and count on several windows at once.

Reset
REQ-019 SHALL on I_reset asynchronously set all lower, upper, enable to 0, all counters to 0, and O_valid, O_hit, O_any, O_miss, O_index, O_sticky to 0.
REQ-020 SHALL with reset windows report every valid input as miss (all windows empty and disabled).
REQ-021 SHALL on reset asserted mid-stream discard the in-flight result; first valid output after release is from a value sampled after release.

Verification
REQ-022 Write window0 = [0x2000,0x4000) enabled; I_value 0x1FFF, 0x2000, 0x3FFF, 0x4000 valid on consecutive cycles -> O_hit[0] = 0,1,1,0 one cycle later; O_miss = 1,0,0,1.
REQ-023 Window1 = [0x1000,0x3000), window2 = [0x2800,0x2900) enabled; I_value 0x2850 -> O_hit = 0b0111 (with window0), O_index = 0, O_any = 1, counters 0,1,2 each +1.
REQ-024 P_count_width 8, window0 hit 300 consecutive cycles -> O_count (index 0) = 255, O_sticky[0] = 1; then I_clear with simultaneous hit -> count 0, sticky 0.
REQ-025 Write window3 = [0x5000,0x5000) enabled, and [0x6000,0x5000) -> I_value 0x5000 and 0x5800 never hit window3.
REQ-026 I_value 0x2000 valid in same cycle as write disabling window0 -> hit reported; same value next cycle -> miss.
REQ-027 Assert I_reset asynchronously between edges with counters nonzero -> all outputs 0 immediately, O_count = 0, configs cleared.
